// File: rtl/ram_bist_if.sv
// ram_bist_if: BIST control, RAM drive and result signals
interface ram_bist_if #(
  parameter int AW = 7,
  parameter int DW = 8
);
  logic          start;
  logic          en;
  logic [DW-1:0] q;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic          we;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [7:0]    err_cnt;
  modport master(input start, en, q, output a, d, we, busy, done, pass, fail_addr, err_cnt);
  modport slave(output start, en, q, input a, d, we, busy, done, pass, fail_addr, err_cnt);
endinterface

// File: rtl/ram_bist.sv
// ram_bist: two-pass march self-test initiator for a single-port RAM with registered read data
module ram_bist #(
  parameter int            AW    = 7,
  parameter int            DW    = 8,
  parameter int            DEPTH = 128,
  parameter logic [DW-1:0] SEED  = 8'hA5
) (
  input logic        clk,
  input logic        rst,
  ram_bist_if.master bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_t;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, fail_q, fail_d, cmp_addr;
  logic          ph_q, ph_d, skip_q, skip_d, seen_q, seen_d, cmp, mism;
  logic [7:0]    err_q, err_d;
  logic [DW-1:0] d_q, d_d;
  logic          we_q, we_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] ad, input logic ph);
    return (DW'(ad) ^ SEED) ^ {DW{ph}};
  endfunction
  // march sequencing; a READ step consumes the word fetched by the previous step
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ph_d     = ph_q;
    skip_d   = skip_q;
    err_d    = err_q;
    fail_d   = fail_q;
    seen_d   = seen_q;
    cmp      = 1'b0;
    cmp_addr = addr_q - AW'(1);
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d = WRITE;
        addr_d  = '0;
        ph_d    = 1'b0;
        skip_d  = 1'b0;
        err_d   = '0;
        fail_d  = '0;
        seen_d  = 1'b0;
      end
      WRITE: if (bus.en) begin
        addr_d  = addr_q == LAST ? '0 : addr_q + AW'(1);
        state_d = addr_q == LAST ? READ : WRITE;
        skip_d  = addr_q == LAST;
      end
      READ: if (bus.en) begin
        cmp     = !skip_q;
        skip_d  = 1'b0;
        addr_d  = addr_q == LAST ? addr_q : addr_q + AW'(1);
        state_d = addr_q == LAST ? FLUSH : READ;
      end
      FLUSH: if (bus.en) begin
        cmp      = 1'b1;
        cmp_addr = LAST;
        ph_d     = 1'b1;
        addr_d   = ph_q ? addr_q : '0;
        state_d  = ph_q ? DONE : WRITE;
      end
      default: state_d = IDLE;
    endcase
    mism = cmp && (bus.q != pat(cmp_addr, ph_q));
    if (mism) begin
      err_d  = err_q == 8'hFF ? err_q : err_q + 8'd1;
      fail_d = seen_q ? fail_q : cmp_addr;
      seen_d = 1'b1;
    end
  end
  // registered RAM drive and status derived from the next state
  always_comb begin
    we_d   = state_d == WRITE;
    d_d    = we_d ? pat(addr_d, ph_d) : '0;
    busy_d = state_d inside {WRITE, READ, FLUSH};
    done_d = state_d == DONE;
    pass_d = done_d && err_d == 8'd0;
  end
  // all state and outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ph_q    <= 1'b0;
      skip_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      seen_q  <= 1'b0;
      d_q     <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      seen_q  <= seen_d;
      d_q     <= d_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
  assign bus.a         = addr_q;
  assign bus.d         = d_q;
  assign bus.we        = we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_addr = fail_q;
  assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: RAM model with fault injection, table-driven and random BIST runs
module tb_ram_bist;
  logic clk, rst;
  ram_bist_if #(.AW(7), .DW(8)) bus();
  ram_bist dut(.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       fen;
    logic [6:0] fa;
    logic [7:0] m;
    logic       sv;
    logic       tie;
    int         period;
    int         start_mid;
    logic [6:0] watch;
    logic [7:0] w0;
    logic [7:0] w1;
    int         exp_err;
    int         exp_fail;
    logic       exp_pass;
  } vec_t;

  int checks = 0, errors = 0;
  logic [7:0] mem [128];
  logic [7:0] ram_q;
  logic       cur_fen, cur_sv, cur_tie;
  logic [6:0] cur_fa, watch;
  logic [7:0] cur_m;
  logic [7:0] w_log[$];
  vec_t       tbl[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.q = cur_tie ? 8'h00 : ram_q;

  always @(posedge clk) begin
    if (bus.en) begin
      if (bus.we) begin
        mem[bus.a] <= (cur_fen && bus.a == cur_fa) ? ((bus.d & ~cur_m) | (cur_sv ? cur_m : 8'h00)) : bus.d;
        if (bus.a == watch) w_log.push_back(bus.d);
      end
      ram_q <= mem[bus.a];
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [6:0] ad, input int ph);
    return ({1'b0, ad} ^ 8'hA5) ^ (ph != 0 ? 8'hFF : 8'h00);
  endfunction

  // whole-test outcome from the march rules: every word written then read back once per pass
  function automatic void model(input vec_t v, output int err, output int fail);
    logic [7:0] w, r;
    bit seen;
    err = 0;
    fail = 0;
    seen = 0;
    for (int ph = 0; ph < 2; ph++)
      for (int ad = 0; ad < 128; ad++) begin
        w = pat(7'(ad), ph);
        r = v.tie ? 8'h00 : (v.fen && 7'(ad) == v.fa) ? ((w & ~v.m) | (v.sv ? v.m : 8'h00)) : w;
        if (r != w) begin
          if (err < 255) err++;
          if (!seen) begin
            fail = ad;
            seen = 1;
          end
        end
      end
  endfunction

  task automatic run_case(input string nm, input vec_t v);
    int cyc, lim, viol;
    logic en_now, pw;
    logic [6:0] pa;
    logic [7:0] pd;
    cur_fen = v.fen; cur_fa = v.fa; cur_m = v.m; cur_sv = v.sv; cur_tie = v.tie; watch = v.watch;
    w_log.delete();
    bus.en = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({nm, "_busy_after_start"}, bus.busy, 1);
    cyc = 0;
    viol = 0;
    lim = 514 * v.period + 40;
    while (!bus.done && cyc < lim) begin
      en_now = (cyc % v.period) == v.period - 1;
      bus.en = en_now;
      bus.start = (cyc == v.start_mid);
      pa = bus.a; pd = bus.d; pw = bus.we;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc++;
      if (!en_now && (bus.a != pa || bus.d != pd || bus.we != pw)) viol++;
    end
    bus.en = 1'b0;
    check({nm, "_cycles"}, cyc, 514 * v.period);
    check({nm, "_err_cnt"}, bus.err_cnt, v.exp_err);
    check({nm, "_fail_addr"}, bus.fail_addr, v.exp_fail);
    check({nm, "_pass"}, bus.pass, v.exp_pass);
    check({nm, "_busy_done"}, bus.busy, 0);
    check({nm, "_stable_between_steps"}, viol, 0);
    check({nm, "_watch_writes"}, w_log.size(), 2);
    if (w_log.size() == 2) begin
      check({nm, "_watch_w0"}, w_log[0], v.w0);
      check({nm, "_watch_w1"}, w_log[1], v.w1);
    end
  endtask

  initial begin
    vec_t v;
    int e, f, n;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    ram_q = 8'h00;
    cur_fen = 0; cur_fa = 0; cur_m = 0; cur_sv = 0; cur_tie = 0; watch = 7'h05;
    bus.en = 1'b0;
    bus.start = 1'b1;
    rst = 1'b0;
    tbl[0] = '{1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1, -1, 7'h05, 8'hA0, 8'h5F, 0, 0, 1'b1};
    tbl[1] = '{1'b1, 7'h10, 8'h08, 1'b0, 1'b0, 1, -1, 7'h10, 8'hB5, 8'h4A, 1, 'h10, 1'b0};
    tbl[2] = '{1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 4, -1, 7'h05, 8'hA0, 8'h5F, 0, 0, 1'b1};
    tbl[3] = '{1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1, 100, 7'h5A, 8'hFF, 8'h00, 255, 0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_a", bus.a, 0);
    check("rst_d", bus.d, 0);
    check("rst_we", bus.we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pass", bus.pass, 0);
    check("rst_fail_addr", bus.fail_addr, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    bus.start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start_busy", bus.busy, 0);

    for (int i = 0; i < 4; i++) run_case($sformatf("tbl%0d", i), tbl[i]);

    cur_tie = 0; cur_fen = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!(bus.busy && !bus.we && bus.a == 7'h30) && n < 1000) begin
      bus.en = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("reach_read_30", int'(n < 1000), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.en = 1'b0;
    check("midrst_we", bus.we, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_a", bus.a, 0);
    @(posedge clk); #1;
    check("midrst_stays_idle", bus.busy, 0);
    run_case("after_rst", tbl[0]);

    for (int i = 0; i < 6; i++) begin
      v.fen = 1'b1;
      v.fa = 7'($urandom_range(0, 127));
      v.m = 8'(1 << $urandom_range(0, 7));
      v.sv = 1'($urandom_range(0, 1));
      v.tie = 1'b0;
      v.period = $urandom_range(1, 3);
      v.start_mid = $urandom_range(0, 1) != 0 ? $urandom_range(0, 400) : -1;
      v.watch = v.fa;
      v.w0 = pat(v.fa, 0);
      v.w1 = pat(v.fa, 1);
      model(v, e, f);
      v.exp_err = e;
      v.exp_fail = f;
      v.exp_pass = (e == 0);
      run_case($sformatf("rnd%0d", i), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_bist.md
# ram_bist

Built-in self-test initiator that drives the address, data and write-enable side of the 128 x 8 single-port RAM and checks its registered read data. It runs a two-pass march:
- write pattern, read and compare;
- write inverted pattern, read and compare.

It reports pass/fail, the first failing address and a saturating error count. It sits beside the RAM and owns its `a`/`d`/`we` inputs during test. It is paced by a step enable that marks the RAM's sampling edges.

## Interface
- `AW`, 7, address width
- `DW`, 8, data width
- `DEPTH`, 128, number of words (2**AW)
- `SEED`, 8'hA5, pattern seed
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset: synchronous, active-low (low on a rising `clk` edge resets the block)
- `start`  in  1  begin a test; sampled only in IDLE/DONE
- `en`  in  1  step enable; RAM samples `a`/`d`/`we` at the `clk` edge ending a cycle with `en`=1
- `q`  in  DW  RAM registered read data
- `a`  out  AW  RAM address
- `d`  out  DW  RAM write data
- `we`  out  1  RAM write enable
- `busy`  out  1  test in progress
- `done`  out  1  test finished, results valid
- `pass`  out  1  1 when `done` and `err_cnt`==0
- `fail_addr`  out  AW  address of first mismatch (0 if none)
- `err_cnt`  out  8  mismatch count, saturating at 255

## Operation
- Pattern: p(addr, ph) = ({1'b0, addr} ^ SEED), inverted when ph=1.
- Registers: `state`, `addr`, `ph`, `err_cnt`, `fail_addr`, `first_seen`.
- Output drive:
  - `a` = `addr`.
  - `we` = (state==WRITE).
  - `d` = p(addr, ph) in WRITE, else 0.
- Reset values: state IDLE, and `a`, `d`, `we`, `busy`, `done`, `pass`, `fail_addr`, `err_cnt`, `ph` all 0.
- States and transitions:
  - IDLE / DONE:
    - `start`=1 on any `clk` edge (`en` not required) -> WRITE.
    - On that edge: `addr`=0, `ph`=0, `err_cnt`=0, `fail_addr`=0, `first_seen`=0, `done`=0.
  - WRITE, on each `en` step:
    - RAM stores p(addr, ph); `addr`++.
    - After the step with `addr`==DEPTH-1: `addr`=0 -> READ, with the `skip` flag set.
  - READ, on each `en` step:
    - If `skip` is clear, compare `q` with p(addr-1, ph).
    - Clear `skip`; `addr`++.
    - After `addr`==DEPTH-1: -> FLUSH; `addr` holds DEPTH-1.
  - FLUSH, on the `en` step:
    - Compare `q` with p(DEPTH-1, ph).
    - If `ph`==0: `ph`=1, `addr`=0 -> WRITE.
    - Else -> DONE.
  - DONE: `done`=1, `busy`=0, `pass`=(`err_cnt`==0); results hold until the next `start`.
- Mismatch handling:
  - `err_cnt` increments, saturating at 255.
  - The first mismatch loads `fail_addr` with the compared address and sets `first_seen`.
  - Later mismatches leave `fail_addr` unchanged.
- `busy`=1 in WRITE, READ and FLUSH.
- `start` while busy is ignored.
- `en`=0 freezes all state; outputs hold.

## Timing
- Read latency: the RAM updates `q` at a read step, and the block consumes that `q` at the next `en` step. FLUSH absorbs the last word of each pass.
- Steps per pass: DEPTH writes + DEPTH reads + 1 flush = 257.
- Full test: 514 `en` steps. `done` rises at the edge of the 514th step after `start` acceptance.
- `a`, `d` and `we` change only at `en` edges, the `start` edge or reset. They are stable for the whole step period.
- Reset mid-run (`rst`=0 at any edge):
  - State returns to IDLE, `we`=0 and all outputs clear on that edge.
  - RAM contents are undefined afterwards.
- `start` and `rst`=0 on the same edge: reset wins.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `start`=1 -> all outputs 0, state stays IDLE.
- Good RAM model, `en`=1 every cycle, one `start` pulse:
  - addr 0x05 is written with 0xA0 in pass 0 and 0x5F in pass 1.
  - `done` rises 514 cycles after the start edge, with `pass`=1 and `err_cnt`=0.
- Fault at addr 0x10, bit 3 stuck-at-0:
  - Pass 1 writes 0x4A and reads 0x42.
  - Final result: `err_cnt`=1, `fail_addr`=0x10, `pass`=0.
- `en` one cycle in four:
  - Same results as the good-RAM case; `done` after 2056 cycles.
  - `a`/`d`/`we` never change between steps.
- `rst`=0 for one cycle while in READ at addr 0x30:
  - Next edge: `we`=0, `busy`=0, IDLE.
  - A new `start` then completes with `pass`=1.
- `q` tied to 0x00 plus a `start` pulse issued mid-run:
  - The mid-run `start` is ignored.
  - Pass 0 gives 128 mismatches; pass 1 gives 127, because addr 0x5A expects 0x00.
  - Final result: `err_cnt`=255, `fail_addr`=0x00.
